event_record_assembler: RTL and testbench

EVENT_RECORD_ASSEMBLER -- requirements
Module: event_record_assembler

---
 rtl/event_record_assembler_pkg.sv | 17 +
 rtl/event_record_assembler_if.sv | 23 ++
 rtl/event_record_assembler_sat_counter.sv | 15 +
 rtl/event_record_assembler.sv | 84 ++++++++
 tb/tb_event_record_assembler.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/event_record_assembler_pkg.sv
// event_record_types: record layout constants, side codes and assembler FSM states
package event_record_types;
  localparam int REC_W     = 256;
  localparam int TS_LSB    = 0;
  localparam int TS_W      = 64;
  localparam int UID_LSB   = 64;
  localparam int UID_W     = 64;
  localparam int SIDE_LSB  = 128;
  localparam int SIDE_W    = 8;
  localparam int PRICE_LSB = 136;
  localparam int PRICE_W   = 32;
  localparam int QTY_LSB   = 168;
  localparam int QTY_W     = 32;
  localparam logic [7:0] SIDE_BID = 8'h00;
  localparam logic [7:0] SIDE_ASK = 8'h01;
  typedef enum logic {COLLECT, DRAIN} state_t;
endpackage

// File: rtl/event_record_assembler_if.sv
// event_record_assembler_if: beat stream in, unpacked record fields out
interface event_record_assembler_if #(parameter int IN_W = 64);
  logic [IN_W-1:0] s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tlast;
  logic            s_axis_tready;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [63:0]     ts_ns;
  logic [63:0]     update_id;
  logic [7:0]      side;
  logic [31:0]     price_f32;
  logic [31:0]     qty_f32;
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast, ts_ns, update_id, side, price_f32, qty_f32
  );
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast, ts_ns, update_id, side, price_f32, qty_f32
  );
endinterface

// File: rtl/event_record_assembler_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/event_record_assembler.sv
// event_record_assembler: gathers IN_W beats into 256-bit records and unpacks the fields.
// Define EVT_SIDE_CHECK_EN to drop records whose side is neither bid nor ask.
module event_record_assembler
  import event_record_types::*;
#(
  parameter int IN_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  event_record_assembler_if.slave bus,
  output logic [CNT_W-1:0] rec_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] side_err_cnt,
  output logic             frame_err
);
  localparam int BEATS = REC_W / IN_W;
  localparam int IDX_W = BEATS > 1 ? $clog2(BEATS) : 1;
  state_t state, state_nxt;
  logic [IDX_W-1:0] beat_idx;
  logic [REC_W-1:0] rec, full_rec;
  logic last_idx, tready, take, collect, good, ferr, emit, side_bad, side_ok;
  assign last_idx = beat_idx == IDX_W'(BEATS - 1);
  assign bus.s_axis_tready = tready;
  assign bus.m_axis_tlast  = bus.m_axis_tvalid;
  // the final beat is merged combinationally so fields load on the accepting edge
  always_comb begin
    full_rec = rec;
    full_rec[beat_idx*IN_W +: IN_W] = bus.s_axis_tdata;
  end
`ifdef EVT_SIDE_CHECK_EN
  assign side_ok = full_rec[SIDE_LSB +: SIDE_W] inside {SIDE_BID, SIDE_ASK};
`else
  assign side_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= COLLECT;
    else state <= state_nxt;
  always_comb
    state_nxt = !take ? state :
                state == COLLECT ? ((last_idx && !bus.s_axis_tlast) ? DRAIN : COLLECT) :
                bus.s_axis_tlast ? COLLECT : DRAIN;
  // only the final beat needs room in the output register
  always_comb begin
    tready   = state == DRAIN || !last_idx || !bus.m_axis_tvalid || bus.m_axis_tready;
    take     = bus.s_axis_tvalid && tready;
    collect  = take && state == COLLECT;
    good     = collect && last_idx && bus.s_axis_tlast;
    ferr     = collect && (last_idx != bus.s_axis_tlast);
    emit     = good && side_ok;
    side_bad = good && !side_ok;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_idx          <= '0;
      rec               <= '0;
      frame_err         <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
      bus.ts_ns         <= '0;
      bus.update_id     <= '0;
      bus.side          <= '0;
      bus.price_f32     <= '0;
      bus.qty_f32       <= '0;
    end else begin
      frame_err <= ferr;
      if (collect) begin
        rec      <= full_rec;
        beat_idx <= (last_idx || bus.s_axis_tlast) ? '0 : beat_idx + 1'b1;
      end
      if (emit) begin
        bus.m_axis_tvalid <= 1'b1;
        bus.ts_ns         <= full_rec[TS_LSB +: TS_W];
        bus.update_id     <= full_rec[UID_LSB +: UID_W];
        bus.side          <= full_rec[SIDE_LSB +: SIDE_W];
        bus.price_f32     <= full_rec[PRICE_LSB +: PRICE_W];
        bus.qty_f32       <= full_rec[QTY_LSB +: QTY_W];
      end else if (bus.m_axis_tready) begin
        bus.m_axis_tvalid <= 1'b0;
      end
    end
  sat_counter #(.W(CNT_W)) u_rec_cnt  (.clk(clk), .rst_n(rst_n), .inc(emit),     .clr(1'b0), .cnt(rec_cnt));
  sat_counter #(.W(CNT_W)) u_ferr_cnt (.clk(clk), .rst_n(rst_n), .inc(ferr),     .clr(1'b0), .cnt(frame_err_cnt));
  sat_counter #(.W(CNT_W)) u_serr_cnt (.clk(clk), .rst_n(rst_n), .inc(side_bad), .clr(1'b0), .cnt(side_err_cnt));
endmodule

// File: tb/tb_event_record_assembler.sv
// tb_event_record_assembler: directed table, hold/reset sequences and random frames vs a frame-level model
module tb_event_record_assembler;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  event_record_assembler_if #(.IN_W(64))  b64();
  event_record_assembler_if #(.IN_W(32))  b32();
  event_record_assembler_if #(.IN_W(256)) b256();
  logic [31:0] rec_cnt, ferr_cnt, serr_cnt, r256, f256, s256;
  logic [1:0]  r32, f32, s32;
  logic        fe, fe32, fe256;
  event_record_assembler #(.IN_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(b64.slave),
    .rec_cnt(rec_cnt), .frame_err_cnt(ferr_cnt), .side_err_cnt(serr_cnt), .frame_err(fe));
  event_record_assembler #(.IN_W(32), .CNT_W(2)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave),
    .rec_cnt(r32), .frame_err_cnt(f32), .side_err_cnt(s32), .frame_err(fe32));
  event_record_assembler #(.IN_W(256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(b256.slave),
    .rec_cnt(r256), .frame_err_cnt(f256), .side_err_cnt(s256), .frame_err(fe256));

  int tests = 0, fails = 0;
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mkrec(logic [63:0] ts, logic [63:0] uid, logic [7:0] sd,
                                         logic [31:0] pr, logic [31:0] qt);
    return {56'hA5A5A5A5A5A5A5, qt, pr, sd, uid, ts};
  endfunction
  function automatic logic [199:0] got64();
    return {b64.qty_f32, b64.price_f32, b64.side, b64.update_id, b64.ts_ns};
  endfunction
  function automatic logic [255:0] rand_rec();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic bit side_valid(logic [7:0] s);
`ifdef EVT_SIDE_CHECK_EN
    return s == 8'h00 || s == 8'h01;
`else
    return 1'b1;
`endif
  endfunction

  // frame-level model: a frame (beats up to tlast) is a record only if it is exactly 4 beats
  int m_rec = 0, m_ferr = 0, m_serr = 0;
  logic [199:0] exq[$];
  task automatic model_frame(logic [255:0] r, int len);
    if (len != 4) m_ferr++;
    else if (!side_valid(r[135:128])) m_serr++;
    else begin
      m_rec++;
      exq.push_back(r[199:0]);
    end
  endtask

  bit rnd = 0;
  int stalls = 0;
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) b64.m_axis_tready = ($urandom_range(0, 3) != 0);
  endtask
  task automatic send_beat(logic [63:0] d, logic l);
    bit r;
    int w = 0;
    b64.s_axis_tdata = d;
    b64.s_axis_tlast = l;
    b64.s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      r = b64.s_axis_tready;
      tick();
      if (r) break;
      stalls++;
      w++;
      if (w > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    b64.s_axis_tvalid = 1'b0;
  endtask
  task automatic send_frame(logic [255:0] r, int len);
    logic [63:0] d;
    for (int i = 0; i < len; i++) begin
      if (i < 4) d = r[i*64 +: 64];
      else d = {$urandom, $urandom};
      send_beat(d, i == len - 1);
    end
  endtask

  bit sb_on = 0, held_v = 0;
  int n_out = 0, fe_pulses = 0;
  logic [199:0] held;
  always @(negedge clk) if (sb_on) begin
    if (held_v) chk("hold_stable", {b64.m_axis_tvalid, got64()}, {1'b1, held});
    held_v = b64.m_axis_tvalid && !b64.m_axis_tready;
    held = got64();
    if (fe) fe_pulses++;
    if (b64.m_axis_tvalid && b64.m_axis_tready) begin
      n_out++;
      chk("out_tlast", b64.m_axis_tlast, 1);
      if (exq.size() == 0) chk("unexpected_out", 1, 0);
      else chk("out_fields", got64(), exq.pop_front());
    end
  end

  typedef struct {
    int len;
    logic [255:0] rec;
    bit out;
    bit fe;
    int dferr;
    int dserr;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [255:0] a, b, r;
    int low, stable, len, f0;
    {b64.s_axis_tdata, b64.s_axis_tvalid, b64.s_axis_tlast} = '0;
    {b32.s_axis_tdata, b32.s_axis_tvalid, b32.s_axis_tlast} = '0;
    {b256.s_axis_tdata, b256.s_axis_tvalid, b256.s_axis_tlast} = '0;
    b64.m_axis_tready = 1'b1;
    b32.m_axis_tready = 1'b1;
    b256.m_axis_tready = 1'b1;
    tbl.push_back('{4, mkrec(64'h1, 64'h2, 8'h01, 32'h3F800000, 32'h40000000), 1, 0, 0, 0});
    tbl.push_back('{2, mkrec(64'hBAD, 64'hBAD, 8'h01, 32'h1, 32'h1), 0, 1, 1, 0});
    tbl.push_back('{4, mkrec(64'h1122334455667788, 64'hCAFE, 8'h00, 32'hC2C80000, 32'h3F000000), 1, 0, 0, 0});
    tbl.push_back('{6, mkrec(64'hDEAD, 64'hDEAD, 8'h00, 32'h2, 32'h2), 0, 0, 1, 0});
    tbl.push_back('{4, mkrec('1, '1, 8'h01, '1, '1), 1, 0, 0, 0});
`ifdef EVT_SIDE_CHECK_EN
    tbl.push_back('{4, mkrec(64'h77, 64'h77, 8'h07, 32'h7, 32'h7), 0, 0, 0, 1});
`else
    tbl.push_back('{4, mkrec(64'h77, 64'h77, 8'h07, 32'h7, 32'h7), 1, 0, 0, 0});
`endif
    tbl.push_back('{1, mkrec(64'h9, 64'h9, 8'h00, 32'h9, 32'h9), 0, 1, 1, 0});
    tbl.push_back('{4, mkrec(64'h0, 64'h0, 8'h00, 32'h0, 32'h0), 1, 0, 0, 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", b64.m_axis_tvalid, 0);
    chk("rst_fields", got64(), 0);
    chk("rst_counters", {rec_cnt, ferr_cnt, serr_cnt}, 0);
    chk("rst_frame_err", fe, 0);
    chk("rst_tready", b64.s_axis_tready, 1);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      send_frame(tbl[i].rec, tbl[i].len);
      m_rec += int'(tbl[i].out);
      m_ferr += tbl[i].dferr;
      m_serr += tbl[i].dserr;
      chk($sformatf("v%0d_valid", i), b64.m_axis_tvalid, tbl[i].out);
      if (tbl[i].out) chk($sformatf("v%0d_fields", i), got64(), tbl[i].rec[199:0]);
      chk($sformatf("v%0d_frame_err", i), fe, tbl[i].fe);
      chk($sformatf("v%0d_rec_cnt", i), rec_cnt, m_rec);
      chk($sformatf("v%0d_ferr_cnt", i), ferr_cnt, m_ferr);
      chk($sformatf("v%0d_serr_cnt", i), serr_cnt, m_serr);
      tick();
      tick();
    end

    a = mkrec(64'hAAAA, 64'hA1, 8'h00, 32'h11, 32'h22);
    b = mkrec(64'hBBBB, 64'hB1, 8'h01, 32'h33, 32'h44);
    b64.m_axis_tready = 1'b0;
    send_frame(a, 4);
    m_rec++;
    chk("hold_a_fields", {b64.m_axis_tvalid, got64()}, {1'b1, a[199:0]});
    stalls = 0;
    for (int i = 0; i < 3; i++) send_beat(b[i*64 +: 64], 1'b0);
    chk("hold_prefix_stalls", stalls, 0);
    b64.s_axis_tdata = b[255:192];
    b64.s_axis_tlast = 1'b1;
    b64.s_axis_tvalid = 1'b1;
    low = 0;
    stable = 0;
    repeat (10) begin
      @(negedge clk);
      if (!b64.s_axis_tready) low++;
      if (b64.m_axis_tvalid && got64() == a[199:0]) stable++;
      tick();
    end
    chk("hold_tready_low", low, 10);
    chk("hold_fields_stable", stable, 10);
    b64.m_axis_tready = 1'b1;
    @(negedge clk);
    chk("hold_release_tready", b64.s_axis_tready, 1);
    tick();
    b64.s_axis_tvalid = 1'b0;
    m_rec++;
    chk("hold_b_fields", {b64.m_axis_tvalid, got64()}, {1'b1, b[199:0]});
    chk("hold_rec_cnt", rec_cnt, m_rec);
    tick();
    chk("hold_drained", b64.m_axis_tvalid, 0);

    sb_on = 1;
    stalls = 0;
    n_out = 0;
    for (int k = 0; k < 100; k++) begin
      r = rand_rec();
      r[135:128] = 8'($urandom_range(0, 1));
      model_frame(r, 4);
      send_frame(r, 4);
    end
    tick();
    tick();
    chk("b2b_stalls", stalls, 0);
    chk("b2b_outputs", n_out, 100);
    chk("b2b_rec_cnt", rec_cnt, m_rec);

    rnd = 1;
    f0 = m_ferr;
    fe_pulses = 0;
    for (int k = 0; k < 150; k++) begin
      r = rand_rec();
      case ($urandom_range(0, 3))
        0: r[135:128] = 8'h00;
        1: r[135:128] = 8'h01;
        default: ;
      endcase
      len = ($urandom_range(0, 9) < 6) ? 4 : $urandom_range(1, 7);
      model_frame(r, len);
      repeat ($urandom_range(0, 2)) tick();
      send_frame(r, len);
    end
    rnd = 0;
    b64.m_axis_tready = 1'b1;
    repeat (5) tick();
    sb_on = 0;
    chk("rand_queue_empty", exq.size(), 0);
    chk("rand_fe_pulses", fe_pulses, m_ferr - f0);
    chk("rand_rec_cnt", rec_cnt, m_rec);
    chk("rand_ferr_cnt", ferr_cnt, m_ferr);
    chk("rand_serr_cnt", serr_cnt, m_serr);

    b64.m_axis_tready = 1'b0;
    send_frame(a, 4);
    send_beat(b[63:0], 1'b0);
    send_beat(b[127:64], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", b64.m_axis_tvalid, 0);
    chk("midrst_fields", got64(), 0);
    chk("midrst_counters", {rec_cnt, ferr_cnt, serr_cnt, 31'd0, fe}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b64.m_axis_tready = 1'b1;
    tick();
    send_frame(b, 4);
    chk("postrst_fields", {b64.m_axis_tvalid, got64()}, {1'b1, b[199:0]});
    chk("postrst_counts", {rec_cnt, ferr_cnt}, {32'd1, 32'd0});
    tick();

    for (int k = 0; k < 4; k++) begin
      r = rand_rec();
      r[135:128] = 8'h01;
      for (int i = 0; i < 8; i++) begin
        b32.s_axis_tdata = r[i*32 +: 32];
        b32.s_axis_tlast = (i == 7);
        b32.s_axis_tvalid = 1'b1;
        tick();
      end
      b32.s_axis_tvalid = 1'b0;
      chk($sformatf("w32_out%0d", k), {b32.m_axis_tvalid, b32.qty_f32, b32.price_f32, b32.side,
          b32.update_id, b32.ts_ns}, {1'b1, r[199:0]});
      tick();
    end
    chk("w32_rec_cnt_sat", r32, 3);
    chk("w32_ferr_cnt", f32, 0);

    for (int k = 0; k < 4; k++) begin
      r = rand_rec();
      r[135:128] = 8'h00;
      b256.s_axis_tdata = r;
      b256.s_axis_tlast = (k != 1);
      b256.s_axis_tvalid = 1'b1;
      tick();
      b256.s_axis_tvalid = 1'b0;
      if (k == 0 || k == 3)
        chk($sformatf("w256_out%0d", k), {b256.m_axis_tvalid, b256.qty_f32, b256.price_f32,
            b256.side, b256.update_id, b256.ts_ns}, {1'b1, r[199:0]});
      else
        chk($sformatf("w256_drop%0d", k), {b256.m_axis_tvalid, fe256, f256}, {1'b0, k == 1, 32'd1});
      tick();
    end
    chk("w256_rec_cnt", r256, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
